// File: rtl/tlkerr_unpacker_if.sv
// Serial error-status link between the front-end packer and the collector-side unpacker.
// The packer drives d; the unpacker returns the recovered word, strobes and counters.
interface tlkerr_unpacker_if #(
  parameter int NBITS = 18,
  parameter int CNT_W = 8
);
  logic             d;
  logic [NBITS-1:0] errbit;
  logic             valid;
  logic             frame_err;
  logic             done;
  logic             err_any;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] ferr_cnt;

  modport master (
    output d,
    input  errbit, valid, frame_err, done, err_any, frame_cnt, ferr_cnt
  );

  modport slave (
    input  d,
    output errbit, valid, frame_err, done, err_any, frame_cnt, ferr_cnt
  );
endinterface

// File: rtl/tlkerr_unpacker.sv
// Receiver for the TLK error-status frame: start 1, two zero header bits,
// NBITS payload bits LSB first, zero stop bit. Good frames update errbit.
module tlkerr_unpacker #(
  parameter int NBITS = 18,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  tlkerr_unpacker_if.slave bus
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, HDR, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    bitcnt, bitcnt_nxt;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] errbit;
  logic             valid, frame_err, done, err_any;
  logic [CNT_W-1:0] frame_cnt, ferr_cnt;
  logic             good, bad, shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      bitcnt <= '0;
    end else begin
      state  <= state_nxt;
      bitcnt <= bitcnt_nxt;
    end
  end

  // bitcnt counts header bits in HDR, then is reused as the payload index in DATA
  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    good       = 1'b0;
    bad        = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d) begin
          state_nxt  = HDR;
          bitcnt_nxt = '0;
        end
      end
      HDR: begin
        if (bus.d) begin
          bad       = 1'b1;
          state_nxt = IDLE;
        end else if (bitcnt == CW'(1)) begin
          state_nxt  = DATA;
          bitcnt_nxt = '0;
        end else begin
          bitcnt_nxt = bitcnt + CW'(1);
        end
      end
      DATA: begin
        shift = 1'b1;
        if (bitcnt == LAST) begin
          state_nxt = STOP;
        end else begin
          bitcnt_nxt = bitcnt + CW'(1);
        end
      end
      STOP: begin
        state_nxt = IDLE;
        if (bus.d) begin
          bad = 1'b1;
        end else begin
          good = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Until a frame arrives every link is reported bad, hence the all-ones reset
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow    <= '0;
      errbit    <= '1;
      err_any   <= 1'b1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      ferr_cnt  <= '0;
    end else begin
      valid     <= good;
      frame_err <= bad;
      if (shift) begin
        shadow[bitcnt] <= bus.d;
      end
      if (good) begin
        errbit  <= shadow;
        err_any <= |shadow;
        done    <= 1'b1;
        if (frame_cnt != '1) begin
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
      if (bad && (ferr_cnt != '1)) begin
        ferr_cnt <= ferr_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.errbit    = errbit;
  assign bus.valid     = valid;
  assign bus.frame_err = frame_err;
  assign bus.done      = done;
  assign bus.err_any   = err_any;
  assign bus.frame_cnt = frame_cnt;
  assign bus.ferr_cnt  = ferr_cnt;

endmodule
